// File: rtl/audio_reader_pkg.sv
// ============================================================================
//  Module   : audio_reader_pkg
//  Purpose  : Shared state encoding and default widths for the sample reader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_reader_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/audio_sample_reader_if.sv
// ============================================================================
//  Module   : audio_sample_reader_if
//  Purpose  : Avalon-MM read port plus ready/valid sample stream bundle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface audio_sample_reader_if
    import audio_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0]   m_address;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W/8-1:0] m_byteenable;
    logic [DATA_W-1:0]   m_readdata;
    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_ready;

    modport master (
        output m_address, m_chipselect, m_write, m_byteenable,
        input  m_readdata,
        output st_data, st_valid,
        input  st_ready
    );

    modport slave (
        input  m_address, m_chipselect, m_write, m_byteenable,
        output m_readdata,
        input  st_data, st_valid,
        output st_ready
    );
endinterface

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
//  Module   : sample_fifo
//  Purpose  : Show-ahead synchronous FIFO with occupancy count output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    input  wire logic                          push,
    input  wire logic [DATA_W-1:0]             push_data,
    input  wire logic                          pop,
    output      logic [DATA_W-1:0]             pop_data,
    output      logic                          valid,
    output      logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != C_FULL) || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; empty slots are masked on the read side.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign valid    = (r_count != '0);
    assign pop_data = valid ? r_mem[r_rd_ptr] : '0;
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/audio_sample_reader.sv
// ============================================================================
//  Module   : audio_sample_reader
//  Purpose  : Streams a buffer of sample words from on-chip memory, once or looped.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_sample_reader
    import audio_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic              stop,
    input  wire logic              loop_en,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [ADDR_W:0]   num_words,
    audio_sample_reader_if.master  bus,
    output      logic              busy,
    output      logic              done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   C_WORD_ONE = (ADDR_W+1)'(1);
    localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(FIFO_DEPTH);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt, r_base;
    logic [ADDR_W:0]   r_remaining, w_remaining_nxt, r_num;
    logic              r_loop;
    logic              r_inflight;
    logic              r_zero_done;
    logic              w_issue;
    logic              w_drained;
    logic              w_accept;
    logic              w_pop;
    logic              w_st_valid;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W-1:0]  w_occupancy;
    logic [DATA_W-1:0] w_fifo_head;

    assign w_accept    = (r_state == IDLE) && start && (num_words != '0);
    // Credit: a read may only go out if its data is guaranteed a FIFO slot.
    assign w_occupancy = w_fifo_count + CNT_W'(r_inflight);

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_remaining_nxt = r_remaining;
        w_issue         = 1'b0;
        w_drained       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = RUN;
                    w_ptr_nxt       = base_addr;
                    w_remaining_nxt = num_words;
                end
            end
            RUN: begin
                w_issue = (w_occupancy < C_DEPTH);
                if (w_issue) begin
                    w_ptr_nxt       = r_ptr + C_ADDR_ONE;
                    w_remaining_nxt = r_remaining - C_WORD_ONE;
                    if (r_remaining == C_WORD_ONE) begin
                        if (r_loop) begin
                            w_ptr_nxt       = r_base;
                            w_remaining_nxt = r_num;
                        end else begin
                            w_state_nxt = DRAIN;
                        end
                    end
                end
                if (stop) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_drained = !r_inflight && (w_fifo_count == '0);
                if (w_drained) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_base      <= '0;
            r_num       <= '0;
            r_loop      <= 1'b0;
            r_inflight  <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_remaining <= w_remaining_nxt;
            r_inflight  <= w_issue;
            r_zero_done <= (r_state == IDLE) && start && (num_words == '0);
            if (w_accept) begin
                r_base <= base_addr;
                r_num  <= num_words;
                r_loop <= loop_en;
            end
        end
    end

    assign w_pop = w_st_valid && bus.st_ready;

    sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (r_inflight),
        .push_data (bus.m_readdata),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .valid     (w_st_valid),
        .count     (w_fifo_count)
    );

    assign bus.m_address    = r_ptr;
    assign bus.m_chipselect = w_issue;
    assign bus.m_write      = 1'b0;
    assign bus.m_byteenable = '1;
    assign bus.st_data      = w_fifo_head;
    assign bus.st_valid     = w_st_valid;
    assign busy             = (r_state != IDLE);
    assign done             = r_zero_done || w_drained;

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_reader.sv
// ============================================================================
//  Module   : tb_audio_sample_reader
//  Purpose  : Directed table-driven bench for audio_sample_reader.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_audio_sample_reader;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   num;
        int                stall;
        logic [ADDR_W-1:0] exp_last;
        int                exp_stalled_reads;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   num_words = '0;
    logic              busy;
    logic              done;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_pop_cyc = -1;

    logic [ADDR_W-1:0] iss_addr [$];
    int                iss_cyc  [$];
    logic [DATA_W-1:0] rx_data  [$];

    audio_sample_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    audio_sample_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .base_addr (base_addr),
        .num_words (num_words),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return {3'b101, a, 3'b010, ~a};
    endfunction

    // Memory model: fixed read latency of one cycle.
    always @(posedge clk)
        bus.m_readdata <= bus.m_chipselect ? pattern(bus.m_address) : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (bus.m_chipselect) begin
            iss_addr.push_back(bus.m_address);
            iss_cyc.push_back(cyc);
        end
        if (bus.st_valid && bus.st_ready) begin
            rx_data.push_back(bus.st_data);
            last_pop_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        iss_addr.delete();
        iss_cyc.delete();
        rx_data.delete();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                            input logic l, output int sc);
        @(posedge clk); #1;
        base_addr = b; num_words = n; loop_en = l; start = 1'b1; sc = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 13'h1555; num_words = 14'd7; loop_en = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    task automatic check_linear(input string tag, input logic [ADDR_W-1:0] b, input int n);
        chk({tag, "_n_reads"}, 64'(iss_addr.size()), 64'(n));
        chk({tag, "_n_samples"}, 64'(rx_data.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            logic [ADDR_W-1:0] ea;
            ea = b + 13'(k);
            if (k < iss_addr.size()) chk({tag, "_addr"}, 64'(iss_addr[k]), 64'(ea));
            if (k < rx_data.size())  chk({tag, "_data"}, 64'(rx_data[k]), 64'(pattern(ea)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              vecs [4];
        logic [ADDR_W-1:0] exp_loop [8];
        int                start_cyc;
        int                d0;
        bit                ok;

        vecs[0] = '{base: 13'h0010, num: 14'd4, stall: 0,  exp_last: 13'h0013, exp_stalled_reads: 0};
        vecs[1] = '{base: 13'h1FFE, num: 14'd4, stall: 0,  exp_last: 13'h0001, exp_stalled_reads: 0};
        vecs[2] = '{base: 13'h0200, num: 14'd8, stall: 20, exp_last: 13'h0207, exp_stalled_reads: 4};
        vecs[3] = '{base: 13'h1FFF, num: 14'd1, stall: 0,  exp_last: 13'h1FFF, exp_stalled_reads: 0};
        exp_loop = '{13'h100, 13'h101, 13'h102, 13'h100, 13'h101, 13'h102, 13'h100, 13'h101};

        bus.st_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_address",    64'(bus.m_address),    64'(0));
        chk("rst_chipselect", 64'(bus.m_chipselect), 64'(0));
        chk("rst_write",      64'(bus.m_write),      64'(0));
        chk("rst_byteenable", 64'(bus.m_byteenable), 64'(4'hF));
        chk("rst_st_valid",   64'(bus.st_valid),     64'(0));
        chk("rst_st_data",    64'(bus.st_data),      64'(0));
        chk("rst_busy",       64'(busy),             64'(0));
        chk("rst_done",       64'(done),             64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int r = 0; r < 4; r++) begin
            clear_logs();
            bus.st_ready = (vecs[r].stall == 0);
            d0 = done_cnt;
            do_start(vecs[r].base, vecs[r].num, 1'b0, start_cyc);
            if (vecs[r].stall != 0) begin
                repeat (vecs[r].stall) @(negedge clk);
                chk("stall_reads", 64'(iss_addr.size()), 64'(vecs[r].exp_stalled_reads));
                chk("stall_valid", 64'(bus.st_valid), 64'(1));
                chk("stall_head",  64'(bus.st_data), 64'(pattern(vecs[r].base)));
                @(posedge clk); #1;
                bus.st_ready = 1'b1;
            end
            wait_done(200, ok);
            chk("vec_done_seen", 64'(ok), 64'(1));
            @(negedge clk);
            chk("vec_busy_after", 64'(busy), 64'(0));
            chk("vec_done_count", 64'(done_cnt - d0), 64'(1));
            chk("vec_done_after_pop", 64'(done_cyc - last_pop_cyc), 64'(1));
            check_linear("vec", vecs[r].base, int'(vecs[r].num));
            if (iss_addr.size() == int'(vecs[r].num)) begin
                chk("vec_last_addr", 64'(iss_addr[iss_addr.size()-1]), 64'(vecs[r].exp_last));
                chk("vec_first_issue", 64'(iss_cyc[0] - start_cyc), 64'(1));
                if (vecs[r].stall == 0)
                    chk("vec_back_to_back", 64'(iss_cyc[iss_cyc.size()-1] - iss_cyc[0]),
                        64'(vecs[r].num - 1));
            end
        end

        // Looped playback, then stop mid-stream.
        clear_logs();
        bus.st_ready = 1'b1;
        d0 = done_cnt;
        do_start(13'h100, 14'd3, 1'b1, start_cyc);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (iss_addr.size() >= 8) ok = 1'b1;
        end
        chk("loop_reached", 64'(ok), 64'(1));
        if (iss_addr.size() >= 8) begin
            for (int k = 0; k < 8; k++) chk("loop_addr", 64'(iss_addr[k]), 64'(exp_loop[k]));
            chk("loop_no_gap", 64'(iss_cyc[7] - iss_cyc[0]), 64'(7));
        end
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        wait_done(50, ok);
        chk("loop_done_seen", 64'(ok), 64'(1));
        @(negedge clk);
        chk("loop_busy_after", 64'(busy), 64'(0));
        chk("loop_done_count", 64'(done_cnt - d0), 64'(1));
        chk("loop_all_delivered", 64'(rx_data.size()), 64'(iss_addr.size()));
        for (int k = 0; k < rx_data.size() && k < iss_addr.size(); k++)
            chk("loop_data", 64'(rx_data[k]), 64'(pattern(iss_addr[k])));

        // Zero-length transfer.
        clear_logs();
        d0 = done_cnt;
        do_start(13'h040, 14'd0, 1'b0, start_cyc);
        repeat (3) @(negedge clk);
        chk("zero_reads",     64'(iss_addr.size()), 64'(0));
        chk("zero_done_cyc",  64'(done_cyc - start_cyc), 64'(1));
        chk("zero_done_count", 64'(done_cnt - d0), 64'(1));
        chk("zero_busy",      64'(busy), 64'(0));

        // Start while busy is ignored.
        clear_logs();
        d0 = done_cnt;
        do_start(13'h300, 14'd6, 1'b0, start_cyc);
        @(posedge clk); #1;
        base_addr = 13'h050; num_words = 14'd2; loop_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100, ok);
        chk("restart_done_seen", 64'(ok), 64'(1));
        @(negedge clk);
        chk("restart_done_count", 64'(done_cnt - d0), 64'(1));
        check_linear("restart", 13'h300, 6);

        // Asynchronous reset in the middle of a stalled transfer.
        clear_logs();
        bus.st_ready = 1'b0;
        do_start(13'h400, 14'd8, 1'b0, start_cyc);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cyc == start_cyc + 4) ok = 1'b1;
        end
        #2;
        chk("pre_rst_chipselect", 64'(bus.m_chipselect), 64'(1));
        chk("pre_rst_valid",      64'(bus.st_valid), 64'(1));
        chk("pre_rst_busy",       64'(busy), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_chipselect", 64'(bus.m_chipselect), 64'(0));
        chk("mid_rst_valid",      64'(bus.st_valid), 64'(0));
        chk("mid_rst_data",       64'(bus.st_data), 64'(0));
        chk("mid_rst_busy",       64'(busy), 64'(0));
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        clear_logs();
        bus.st_ready = 1'b1;
        d0 = done_cnt;
        do_start(13'h020, 14'd2, 1'b0, start_cyc);
        wait_done(50, ok);
        chk("post_rst_done_seen", 64'(ok), 64'(1));
        @(negedge clk);
        chk("post_rst_done_count", 64'(done_cnt - d0), 64'(1));
        check_linear("post_rst", 13'h020, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
